seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Runtime-programmable Moore serial sequence detector. It generalises the fixed 3-bit "101" detector to any pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection, a valid qualifier on the input stream, and a saturating match counter. It sits on the serial input path of the sequence-detector family and feeds status and interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, width of the match counter.
- RST_PATTERN, 'b101, pattern loaded at reset. Bit 0 is the first bit received.
- RST_LEN, 3, pattern length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- x, input, 1, serial data bit.
- x_valid, input, 1, x is consumed on the edge where x_valid=1.
- cfg_load, input, 1, strobe that captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, MAX_LEN, new pattern; bit i is the i-th bit received.
- cfg_len, input, $clog2(MAX_LEN)+1, new pattern length.
- cfg_overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- match, output, 1, Moore output: high while the state equals L.
- match_pulse, output, 1, one-cycle pulse on entry to state L.
- match_count, output, CNT_W, saturating count of matches.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state=0, history cleared, pattern=RST_PATTERN, L=RST_LEN, overlap=RST_OVERLAP, match=0, match_pulse=0, match_count=0.
- State: cst holds the matched-prefix length, 0..L. match=(cst==L) && (L!=0), decoded directly from the state register with no input term.
- Accepted bit (x_valid=1): shift x into a MAX_LEN-deep history register; this register resets to zero.
- Effective start state: eff = 0 if cst==L and overlap=0; otherwise eff = cst.
- Next state: the largest k ≤ min(eff+1, L) such that the k most recent accepted bits, including x, equal pattern[0..k-1] in arrival order. If no such k exists, the next state is 0.
- Consequence: in overlap mode a match is followed by the longest proper border of the pattern; in non-overlap mode the bit after a match starts a fresh search.
- x_valid=0: state, history, match and match_count all hold. match stays high if it was already high.
- Latency: match rises on the clock edge that samples the final pattern bit, i.e. it is visible the cycle after that bit is presented.
- match_pulse and match_count update on every transition into state L, including L→L in overlap mode (for example, pattern "11" on a stream of 1s).
- Counter: match_count saturates at 2^CNT_W−1 and never wraps.
- cfg_load=1: register the new configuration and set state and history to 0; match_count holds. cfg_load has priority over a simultaneous x_valid, and that bit is discarded.
- Length rules:
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - cfg_len == 0 disables detection: the state is forced to 0 and match never asserts.
  - Pattern bits at index ≥ L are ignored.
- Reset mid-stream: a partial match is lost and the reset configuration is restored.
- Implementation form: next-state logic is combinational, a loop over k with comparison masks, plus a single registered state. Target 120–400 lines of RTL.

Decomposition:
- Package seq_detect_pkg:
  - LEN_W = $clog2(MAX_LEN)+1;
  - localparams for the default pattern, length and overlap;
  - a function prefix_match(hist, pattern, k) returning 1 when the k most recent bits equal the pattern prefix.
- Sub-module: seq_next_state, a purely combinational computation of the next prefix length from (eff, history, x, pattern, L). The top level owns the registers, configuration capture and counter.

Test Plan:
- Defaults after reset (101, overlap on). Stream 1,0,1,0,1,0,1 with x_valid=1 → match high after bits 3, 5 and 7; match_count=3.
- cfg_load with pattern 101, len 3, overlap 0. Same stream → match high after bits 3 and 7 only; match_count=2.
- cfg_load with pattern 4'b0110 (bit order 0,1,1,0), len 4, overlap 1. Stream 0,1,1,0,1,1,0 → matches after bits 4 and 7. Hold x_valid=0 for 5 cycles after bit 4 → match stays high and the count does not change.
- Pattern "11", len 2, overlap 1. Stream of six 1s → match high from bit 2 onward; match_pulse on bits 2–6; match_count=5. Repeat with overlap 0 → matches on bits 2, 4 and 6 only.
- CNT_W=4 with 20 matches → match_count=15 (saturates). cfg_load with cfg_len=0 on a stream of 1s → match never asserts. cfg_len=MAX_LEN+3 → behaves as length MAX_LEN.
- cfg_load coincident with x_valid=1 mid-match → that bit is discarded and state is 0. Apply reset after 2 of 3 bits → state returns to 0 and the completing bit alone does not assert match.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial sequence detector.
//   DEF_*        : default parameter values (pattern 101, length 3, overlap on)
//   LEN_W        : width of a length field for the default MAX_LEN
//   prefix_match : 1 when the k most recent bits equal pattern[0..k-1]
package seq_detect_pkg;

   localparam int          DEF_MAX_LEN = 8;
   localparam int          DEF_CNT_W   = 16;
   localparam int          LEN_W       = $clog2(DEF_MAX_LEN) + 1;
   localparam logic [31:0] DEF_PATTERN = 32'b101;
   localparam int          DEF_LEN     = 3;
   localparam bit          DEF_OVERLAP = 1'b1;

   // Fixed working width for the helper; callers zero-extend to it.
   localparam int PM_W  = 32;
   localparam int PM_IW = 5;

   // hist bit 0 is the most recent bit. The oldest of the k bits (hist[k-1])
   // must equal pattern[0], so hist[j] is compared with pattern[k-1-j].
   function automatic logic prefix_match(input logic [PM_W-1:0] hist,
                                         input logic [PM_W-1:0] pattern,
                                         input int              k);
      logic ok;
      ok = 1'b1;
      for (int j = 0; j < PM_W; j++) begin
         if (j < k) begin
            if (hist[PM_IW'(j)] != pattern[PM_IW'(k - 1 - j)]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/seq_detect_prog_next.sv
// Combinational next-state search for the sequence detector.
//   eff_i     : effective start state (matched-prefix length)
//   hist_i    : accepted-bit history before x_i, bit 0 most recent
//   x_i       : bit being accepted this cycle
//   pattern_i : pattern, bit i is the i-th bit received
//   len_i     : active pattern length L
//   nxt_o     : largest k <= min(eff+1, L) whose prefix matches, else 0
module seq_next_state
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN) + 1
) (
   input  logic [LW-1:0]      eff_i,
   input  logic [MAX_LEN-1:0] hist_i,
   input  logic               x_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [LW-1:0]      len_i,
   output logic [LW-1:0]      nxt_o
);

   logic [PM_W-1:0] h_ext;
   logic [PM_W-1:0] p_ext;

   // Ascending loop: the last k that qualifies is the largest one.
   // k never exceeds eff+1, so history bits from before the last
   // clear are never consulted.
   always_comb begin
      h_ext                = '0;
      h_ext[MAX_LEN-1:0]   = {hist_i[MAX_LEN-2:0], x_i};
      p_ext                = '0;
      p_ext[MAX_LEN-1:0]   = pattern_i;
      nxt_o                = '0;
      for (int k = 1; k <= MAX_LEN; k++) begin
         if ((k <= int'(eff_i) + 1) && (k <= int'(len_i)) &&
             prefix_match(h_ext, p_ext, k))
            nxt_o = LW'(k);
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable Moore serial sequence detector.
//   clk, reset   : clock, synchronous active-high reset
//   x, x_valid   : serial bit and its qualifier
//   cfg_load     : capture cfg_pattern / cfg_len / cfg_overlap, clear search
//   match        : high while state == L (L != 0)
//   match_pulse  : one cycle on each transition into state L
//   match_count  : saturating count of those transitions
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int                 MAX_LEN     = DEF_MAX_LEN,
   parameter int                 CNT_W       = DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
   parameter int                 RST_LEN     = DEF_LEN,
   parameter bit                 RST_OVERLAP = DEF_OVERLAP,
   localparam int                LW          = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x,
   input  logic               x_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   output logic               match,
   output logic               match_pulse,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_RST = LW'((RST_LEN > MAX_LEN) ? MAX_LEN : RST_LEN);

   logic [MAX_LEN-1:0] pat_q,   pat_d;
   logic [LW-1:0]      len_q,   len_d;
   logic               ovl_q,   ovl_d;
   logic [LW-1:0]      cst_q,   cst_d;
   logic [MAX_LEN-1:0] hist_q,  hist_d;
   logic               pulse_q, pulse_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic               at_l;
   logic [LW-1:0]      eff;
   logic [LW-1:0]      nxt;

   assign at_l = (cst_q == len_q) && (len_q != '0);
   // Non-overlap: once matched, the next bit starts a fresh search.
   assign eff  = ((cst_q == len_q) && !ovl_q) ? '0 : cst_q;

   seq_next_state #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_next (
      .eff_i     (eff),
      .hist_i    (hist_q),
      .x_i       (x),
      .pattern_i (pat_q),
      .len_i     (len_q),
      .nxt_o     (nxt)
   );

   always_comb begin
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      cst_d   = cst_q;
      hist_d  = hist_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (cfg_load) begin
         // A bit presented with the load strobe is dropped.
         pat_d  = cfg_pattern;
         len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
         ovl_d  = cfg_overlap;
         cst_d  = '0;
         hist_d = '0;
      end else if (x_valid) begin
         hist_d = {hist_q[MAX_LEN-2:0], x};
         cst_d  = nxt;
         if ((nxt == len_q) && (len_q != '0)) begin
            pulse_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q   <= RST_PATTERN;
         len_q   <= LEN_RST;
         ovl_q   <= RST_OVERLAP;
         cst_q   <= '0;
         hist_q  <= '0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         cst_q   <= cst_d;
         hist_q  <= hist_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match       = at_l;
   assign match_pulse = pulse_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: table-driven vectors through a scoreboard queue,
// plus hand-written reset / load-collision sequences.
module tb_seq_detect_prog;

   localparam int ML = 8;
   localparam int CW = 4;
   localparam int LW = $clog2(ML) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          x = 1'b0;
   logic          x_valid = 1'b0;
   logic          cfg_load = 1'b0;
   logic [ML-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic          match;
   logic          match_pulse;
   logic [CW-1:0] match_count;

   seq_detect_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .x_valid     (x_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .match       (match),
      .match_pulse (match_pulse),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic x; logic v; logic ld;
      logic m; logic p; int cnt;
   } vec_t;

   typedef struct {
      logic m; logic p; int cnt; string name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic xi, vi, ldi, mi, pi, input int ci);
      vec_t r;
      r.x = xi; r.v = vi; r.ld = ldi; r.m = mi; r.p = pi; r.cnt = ci;
      tbl.push_back(r);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: empty queue, nothing to compare");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (match !== e.m) begin
         errors++;
         $display("FAIL %s match: got %0b want %0b", e.name, match, e.m);
      end
      checks++;
      if (match_pulse !== e.p) begin
         errors++;
         $display("FAIL %s pulse: got %0b want %0b", e.name, match_pulse, e.p);
      end
      checks++;
      if (int'(match_count) != e.cnt) begin
         errors++;
         $display("FAIL %s count: got %0d want %0d", e.name, match_count, e.cnt);
      end
   endtask

   task automatic step(input logic xi, vi, ldi, mi, pi, input int ci,
                       input string nm);
      @(negedge clk);
      x = xi; x_valid = vi; cfg_load = ldi;
      sb.push_back('{mi, pi, ci, nm});
      @(posedge clk);
      #1;
      x_valid = 1'b0; cfg_load = 1'b0;
      check_out();
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      reset = 1'b1; x_valid = 1'b1; x = 1'b1; cfg_load = 1'b0;
      sb.push_back('{1'b0, 1'b0, 0, nm});
      @(posedge clk);
      #1;
      reset = 1'b0; x_valid = 1'b0;
      check_out();
   endtask

   task automatic run_table(input string grp);
      foreach (tbl[i])
         step(tbl[i].x, tbl[i].v, tbl[i].ld, tbl[i].m, tbl[i].p, tbl[i].cnt,
              $sformatf("%s[%0d]", grp, i));
      tbl.delete();
   endtask

   task automatic set_cfg(input logic [ML-1:0] p, input logic [LW-1:0] l,
                          input logic o);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o;
   endtask

   initial begin
      do_reset("reset_init");

      // Defaults 101, overlap on
      add(1,1,0, 0,0,0); add(0,1,0, 0,0,0); add(1,1,0, 1,1,1);
      add(0,1,0, 0,0,1); add(1,1,0, 1,1,2); add(0,1,0, 0,0,2);
      add(1,1,0, 1,1,3);
      run_table("dflt_ovl");

      // 101, non-overlap
      do_reset("reset_b");
      set_cfg(8'b101, 4'd3, 1'b0);
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(0,1,0, 0,0,0); add(1,1,0, 1,1,1);
      add(0,1,0, 0,0,1); add(1,1,0, 0,0,1); add(0,1,0, 0,0,1);
      add(1,1,0, 1,1,2);
      run_table("101_novl");

      // 0110 overlap with idle gap while matched
      do_reset("reset_c");
      set_cfg(8'b0110, 4'd4, 1'b1);
      add(0,0,1, 0,0,0);
      add(0,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0);
      add(0,1,0, 1,1,1);
      for (int i = 0; i < 5; i++) add(1,0,0, 1,0,1);
      add(1,1,0, 0,0,1); add(1,1,0, 0,0,1); add(0,1,0, 1,1,2);
      run_table("0110_ovl");

      // 11 overlap: L->L on every further 1
      do_reset("reset_d1");
      set_cfg(8'b11, 4'd2, 1'b1);
      add(0,0,1, 0,0,0);
      for (int i = 0; i < 6; i++) add(1,1,0, i >= 1, i >= 1, i);
      run_table("11_ovl");

      // 11 non-overlap
      do_reset("reset_d2");
      set_cfg(8'b11, 4'd2, 1'b0);
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 1,1,1); add(1,1,0, 0,0,1);
      add(1,1,0, 1,1,2); add(1,1,0, 0,0,2); add(1,1,0, 1,1,3);
      run_table("11_novl");

      // Counter saturation: 20 matches on a 4-bit counter
      do_reset("reset_e");
      set_cfg(8'b11, 4'd2, 1'b1);
      add(0,0,1, 0,0,0);
      for (int i = 0; i < 21; i++) add(1,1,0, i >= 1, i >= 1, (i < 15) ? i : 15);
      run_table("sat");

      // Length 0 disables detection
      do_reset("reset_f");
      set_cfg(8'hFF, 4'd0, 1'b1);
      add(0,0,1, 0,0,0);
      for (int i = 0; i < 10; i++) add(1,1,0, 0,0,0);
      run_table("len0");

      // Oversized length clamps to MAX_LEN
      do_reset("reset_g");
      set_cfg(8'hFF, 4'(ML + 3), 1'b1);
      add(0,0,1, 0,0,0);
      for (int i = 0; i < 9; i++) add(1,1,0, i >= 7, i >= 7, (i >= 7) ? i - 6 : 0);
      run_table("clamp");

      // Load coincident with a completing bit: bit dropped, state cleared
      do_reset("reset_h");
      step(1,1,0, 0,0,0, "coll_b1");
      step(0,1,0, 0,0,0, "coll_b2");
      set_cfg(8'b101, 4'd3, 1'b1);
      step(1,1,1, 0,0,0, "coll_load");
      step(1,1,0, 0,0,0, "coll_r1");
      step(0,1,0, 0,0,0, "coll_r2");
      step(1,1,0, 1,1,1, "coll_r3");

      // Reset after two of three bits loses the partial match
      do_reset("reset_i");
      step(1,1,0, 0,0,0, "mid_b1");
      step(0,1,0, 0,0,0, "mid_b2");
      do_reset("mid_reset");
      step(1,1,0, 0,0,0, "mid_b3");
      step(0,1,0, 0,0,0, "mid_b4");
      step(1,1,0, 1,1,1, "mid_b5");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left over", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
